// File: rtl/life_gen_scheduler.sv
// Purpose : paces Game of Life generations against VGA frames, launches the update engine, swaps ping-pong banks on vsync.
// Latency : eng_start one cycle after the launching frame tick (or step); bank swap registered on the frame-tick edge.
// Backpress: start/done handshake with one generation in flight; a stalled engine is abandoned after TIMEOUT cycles.
// Optional engine seeding (seed_req/seed_mode) is compiled in when LIFE_SEED_EN is defined.
module life_gen_scheduler #(
    parameter logic        VSYNC_POL = 1'b1,
    parameter int          SPEED_W   = 4,
    parameter int          GEN_W     = 16,
    parameter logic [31:0] TIMEOUT   = 32'd600000
) (
    input  logic               clk_36MHz,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               run,
    input  logic               step,
    input  logic [SPEED_W-1:0] speed,
    output logic               eng_start,
    input  logic               eng_done,
    output logic               disp_bank,
    output logic               work_bank,
    output logic               busy,
    output logic [GEN_W-1:0]   gen_count,
    output logic               timeout_err
`ifdef LIFE_SEED_EN
    ,
    input  logic               seed_req,
    output logic               seed_mode
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        COMPUTE    = 2'd2,
        WAIT_SWAP  = 2'd3
    } state_t;

    state_t             state;
    logic               vsync_q;
    logic               frame_tick;
    logic [SPEED_W-1:0] frame_cnt;
    logic [SPEED_W-1:0] spd_m1;
    logic               interval_done;
    logic [31:0]        wdog;
    logic               idle_go;
    logic               launch;
    logic               do_swap;
    logic               wd_expire;

    // A frame starts on the inactive-to-active edge of vsync.
    assign frame_tick = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

    // speed 0 behaves as 1 frame per generation.
    assign spd_m1 = (speed == '0) ? '0 : speed - SPEED_W'(1);

    // >= rather than == so that lowering speed mid-interval still launches at the next tick.
    assign interval_done = (frame_cnt >= spd_m1);

`ifdef LIFE_SEED_EN
    // A seed request while stopped launches a generation just like step.
    assign idle_go = step | seed_req;
`else
    assign idle_go = step;
`endif

    assign launch = ((state == IDLE) && !run && idle_go) ||
                    ((state == WAIT_FRAME) && run && frame_tick && interval_done);

    // Swap only on a frame tick: either done arrives together with the tick, or the tick ends WAIT_SWAP.
    assign do_swap = frame_tick &&
                     (((state == COMPUTE) && eng_done) || (state == WAIT_SWAP));

    // Done in the last permitted cycle still wins over the watchdog.
    assign wd_expire = (state == COMPUTE) && !eng_done && (wdog == TIMEOUT - 32'd1);

    assign work_bank = ~disp_bank;

    // Register vsync once for edge detection.
    always_ff @(posedge clk_36MHz or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= ~VSYNC_POL;
        end else begin
            vsync_q <= vsync;
        end
    end

    // Generation sequencer: frame pacing, engine launch, watchdog and frame-aligned bank swap.
    always_ff @(posedge clk_36MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            eng_start   <= 1'b0;
            disp_bank   <= 1'b0;
            busy        <= 1'b0;
            gen_count   <= '0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            wdog        <= '0;
        end else begin
            eng_start <= launch;

            if (launch) begin
                wdog <= '0;
            end else if (state == COMPUTE) begin
                wdog <= wdog + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (run) begin
                        state     <= WAIT_FRAME;
                        busy      <= 1'b1;
                        frame_cnt <= '0;
                    end else if (launch) begin
                        state <= COMPUTE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_FRAME: begin
                    if (!run) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (launch) begin
                        state <= COMPUTE;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + SPEED_W'(1);
                    end
                end
                COMPUTE: begin
                    if (eng_done) begin
                        if (!frame_tick) begin
                            state <= WAIT_SWAP;
                        end
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    // Leaves only through the swap below.
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // The swap tick already consumed frame slot 0 of the next interval, hence the load of 1.
            if (do_swap) begin
                disp_bank <= ~disp_bank;
                gen_count <= gen_count + GEN_W'(1);
                frame_cnt <= SPEED_W'(1);
                state     <= run ? WAIT_FRAME : IDLE;
                busy      <= run;
            end
        end
    end

`ifdef LIFE_SEED_EN
    logic seed_pend;

    // Remember seed requests and tag the next engine launch with seed_mode until it completes.
    always_ff @(posedge clk_36MHz or negedge rst_n) begin
        if (!rst_n) begin
            seed_pend <= 1'b0;
            seed_mode <= 1'b0;
        end else if (launch) begin
            seed_mode <= seed_pend | seed_req;
            seed_pend <= 1'b0;
        end else begin
            if (seed_req) begin
                seed_pend <= 1'b1;
            end
            if ((state == COMPUTE) && (eng_done || wd_expire)) begin
                seed_mode <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_life_gen_scheduler.sv
module tb_life_gen_scheduler;

    localparam int P      = 160;   // frame period in clock cycles; ticks at multiples of P
    localparam int TMO    = 1000;
    localparam int EV_START = 0;
    localparam int EV_SWAP  = 1;
    localparam int EV_TMO   = 2;

    logic        clk_36MHz = 1'b0;
    logic        rst_n     = 1'b1;
    logic        vsync     = 1'b0;
    logic        run       = 1'b0;
    logic        step      = 1'b0;
    logic        eng_done  = 1'b0;
    logic [3:0]  speed     = 4'd1;
    logic        eng_start;
    logic        disp_bank;
    logic        work_bank;
    logic        busy;
    logic        timeout_err;
    logic [15:0] gen_count;
`ifdef LIFE_SEED_EN
    logic        seed_req = 1'b0;
    logic        seed_mode;
`endif

    int          cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;
    int          resp_lat = 0;
    logic [15:0] exp_gen  = '0;

    typedef struct {
        int          kind;
        int          at;
        logic [15:0] gen;
    } ev_t;
    ev_t exp_q[$];

    life_gen_scheduler #(
        .VSYNC_POL (1'b1),
        .SPEED_W   (4),
        .GEN_W     (16),
        .TIMEOUT   (32'd1000)
    ) dut (
        .clk_36MHz   (clk_36MHz),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .run         (run),
        .step        (step),
        .speed       (speed),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .disp_bank   (disp_bank),
        .work_bank   (work_bank),
        .busy        (busy),
        .gen_count   (gen_count),
        .timeout_err (timeout_err)
`ifdef LIFE_SEED_EN
        ,
        .seed_req    (seed_req),
        .seed_mode   (seed_mode)
`endif
    );

    always #5 clk_36MHz = ~clk_36MHz;

    always @(posedge clk_36MHz) cyc <= cyc + 1;

    // vsync active for 4 cycles at the start of every P-cycle frame
    initial begin
        forever begin
            @(posedge clk_36MHz);
            #1 vsync = ((cyc % P) < 4);
        end
    end

    // Engine model: answers eng_start with a one-cycle eng_done resp_lat cycles later (0 = never)
    initial begin
        forever begin
            @(negedge clk_36MHz);
            if (rst_n && eng_start && resp_lat > 0) begin
                repeat (resp_lat) @(posedge clk_36MHz);
                #1 eng_done = 1'b1;
                @(posedge clk_36MHz);
                #1 eng_done = 1'b0;
            end
        end
    end

    initial begin
        #(80000 * 10);
        $display("FAIL sim_timeout: reached cycle %0d, required finish before it", cyc);
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            EV_START: return "eng_start";
            EV_SWAP:  return "swap";
            default:  return "timeout";
        endcase
    endfunction

    task automatic push(input int kind, input int at, input logic [15:0] g);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.gen  = g;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", kname(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.at != cyc) begin
            errors++;
            $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                     kname(kind), cyc, kname(e.kind), e.at);
        end else if (kind == EV_SWAP) begin
            chk("gen_count_at_swap", gen_count, e.gen);
            chk("disp_bank_at_swap", disp_bank, e.gen[0]);
            chk("work_bank_at_swap", work_bank, !e.gen[0]);
        end
    endtask

    // Monitor: every DUT event (start pulse, bank change, timeout rise) is matched against the scoreboard
    initial begin
        logic prev_disp;
        logic prev_terr;
        prev_disp = 1'b0;
        prev_terr = 1'b0;
        forever begin
            @(negedge clk_36MHz);
            if (rst_n) begin
                if (eng_start) mon_event(EV_START);
                if (disp_bank != prev_disp) mon_event(EV_SWAP);
                if (timeout_err && !prev_terr) mon_event(EV_TMO);
            end
            prev_disp = disp_bank;
            prev_terr = timeout_err;
        end
    end

    function automatic int tick_from(input int c);
        return ((c + P - 1) / P) * P;
    endfunction

    task automatic goto_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk_36MHz);
            #1;
        end
    endtask

    task automatic goto_phase(input int ph);
        goto_cyc(cyc + 1);
        while ((cyc % P) != ph) goto_cyc(cyc + 1);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        goto_cyc(cyc + 1);
        step = 1'b0;
    endtask

    task automatic end_check(input string name);
        chk({name, "_pending_events"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_gen_count"}, gen_count, exp_gen);
    endtask

    task automatic chk_reset();
        chk("rst_eng_start", eng_start, 0);
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_work_bank", work_bank, 1);
        chk("rst_busy", busy, 0);
        chk("rst_gen_count", gen_count, 0);
        chk("rst_timeout_err", timeout_err, 0);
    endtask

    function automatic int rnd_lat();
        if ($urandom_range(0, 3) == 0) return P - 1;   // done lands exactly on the next tick
        return int'($urandom_range(3, 250));
    endfunction

    // Free-run: an N-frame interval; the swap tick is frame 0 of the next one, and no launch on the swap tick itself.
    task automatic run_free(input int spd, input int lat, input int gens);
        int n, r, tk, s, d, sw, last_s, last_sw, gap;
        n   = (spd == 0) ? 1 : spd;
        gap = (n > 1) ? n - 1 : 1;
        resp_lat = lat;
        goto_phase(30);
        speed = spd[3:0];
        r   = cyc;
        run = 1'b1;
        tk  = tick_from(r + 1) + (n - 1) * P;
        last_s  = 0;
        last_sw = 0;
        for (int g = 1; g <= gens; g++) begin
            s  = tk + 1;
            push(EV_START, s, 16'd0);
            d  = s + lat;
            sw = tick_from(d);
            exp_gen = exp_gen + 16'd1;
            push(EV_SWAP, sw + 1, exp_gen);
            last_s  = s;
            last_sw = sw;
            tk = sw + gap * P;
        end
        goto_cyc(last_s + 2);
        run = 1'b0;                  // dropped during COMPUTE: one final swap, then IDLE
        goto_cyc(last_sw + 3);
        end_check("free_run");
    endtask

    initial begin
        int r, d, sw;
        #1 rst_n = 1'b0;
        #1;
        chk_reset();
        goto_cyc(20);
        rst_n = 1'b1;

        run_free(3, 100, 3);
        run_free(0, P - 1, 3);
        run_free(1, 40, 3);
        run_free(int'($urandom_range(0, 4)), rnd_lat(), 3);
        run_free(int'($urandom_range(0, 4)), rnd_lat(), 3);

        // single step; extra steps while busy are ignored
        resp_lat = 50;
        goto_phase(20);
        r = cyc;
        pulse_step();
        push(EV_START, r + 1, 16'd0);
        d  = r + 1 + 50;
        sw = tick_from(d);
        exp_gen = exp_gen + 16'd1;
        push(EV_SWAP, sw + 1, exp_gen);
        goto_cyc(r + 10);
        pulse_step();
        goto_cyc(d + 5);
        chk("step_wait_swap_busy", busy, 1);
        pulse_step();
        goto_cyc(sw + 3);
        end_check("step");

        // engine never answers: watchdog abort, no swap
        resp_lat = 0;
        goto_phase(20);
        r = cyc;
        pulse_step();
        push(EV_START, r + 1, 16'd0);
        push(EV_TMO, r + 1 + TMO, 16'd0);
        goto_cyc(r + TMO + 5);
        end_check("timeout");
        chk("timeout_err_set", timeout_err, 1);

        run_free(2, int'($urandom_range(3, 120)), 2);
        chk("timeout_err_sticky", timeout_err, 1);

        // reset while waiting for the swap tick
        resp_lat = 5;
        goto_phase(20);
        r = cyc;
        pulse_step();
        push(EV_START, r + 1, 16'd0);
        goto_cyc(r + 30);
        chk("wait_swap_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset();
        exp_gen = '0;
        goto_cyc(r + 40);
        rst_n = 1'b1;
        goto_cyc(tick_from(r + 40) + 3);
        end_check("after_reset");
        chk("after_reset_disp_bank", disp_bank, 0);

        run_free(int'($urandom_range(0, 4)), rnd_lat(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
